// File: rtl/pg_port_reset_pkg.sv
// Shared types and helpers for the per-port soft-reset sequencer.
package pg_port_reset_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2,
    STAGGER = 2'd3
  } t_prst_state;

  // Bits needed to hold 0..max; never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pg_port_reset_fsm.sv
// Single-port reset sequencer: waits for a packet boundary (or timeout),
// holds the port in reset, then releases after a per-port stagger.
module pg_port_reset_fsm
  import pg_port_reset_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int STAGGER_LOAD  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic port_reset_req,
  input  logic tx_tvalid,
  input  logic tx_tready,
  input  logic tx_tlast,
  output logic tx_block,
  output logic port_softreset_n,
  output logic drain_timeout,
  output logic busy
);

  localparam int HOLD_W  = cnt_w(HOLD_CYCLES - 1);
  localparam int DRAIN_W = cnt_w(DRAIN_TIMEOUT - 1);
  localparam int STAG_W  = cnt_w(STAGGER_LOAD);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [STAG_W-1:0]  STAG_LOAD  = STAG_W'(STAGGER_LOAD);

  t_prst_state        state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic [STAG_W-1:0]  stag_cnt_reg, stag_cnt_next;
  logic               in_pkt_reg, in_pkt_next;
  logic               drain_timeout_reg, drain_timeout_next;
  logic               softreset_n_reg;
  logic               beat;

  assign beat = tx_tvalid & tx_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= HOLD;
      hold_cnt_reg      <= HOLD_LOAD;
      drain_cnt_reg     <= DRAIN_LOAD;
      stag_cnt_reg      <= STAG_LOAD;
      in_pkt_reg        <= 1'b0;
      drain_timeout_reg <= 1'b0;
      softreset_n_reg   <= 1'b0;
    end else begin
      state_reg         <= state_next;
      hold_cnt_reg      <= hold_cnt_next;
      drain_cnt_reg     <= drain_cnt_next;
      stag_cnt_reg      <= stag_cnt_next;
      in_pkt_reg        <= in_pkt_next;
      drain_timeout_reg <= drain_timeout_next;
      softreset_n_reg   <= (state_next == RUN) || (state_next == DRAIN);
    end
  end

  always_comb begin
    state_next         = state_reg;
    hold_cnt_next      = hold_cnt_reg;
    drain_cnt_next     = drain_cnt_reg;
    stag_cnt_next      = stag_cnt_reg;
    drain_timeout_next = drain_timeout_reg;
    case (state_reg)
      RUN: begin
        if (port_reset_req) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // A tlast beat on the timeout cycle still counts as a clean drain.
        if (!in_pkt_reg || (beat && tx_tlast)) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
        end else if (drain_cnt_reg == '0) begin
          state_next         = HOLD;
          hold_cnt_next      = HOLD_LOAD;
          drain_timeout_next = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg - 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_reg != '0) begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end else if (!port_reset_req) begin
          state_next    = STAGGER;
          stag_cnt_next = STAG_LOAD;
        end
      end
      STAGGER: begin
        if (port_reset_req) begin
          state_next    = HOLD;
          hold_cnt_next = HOLD_LOAD;
        end else if (stag_cnt_reg == '0) begin
          state_next         = RUN;
          drain_timeout_next = 1'b0;
        end else begin
          stag_cnt_next = stag_cnt_reg - 1'b1;
        end
      end
    endcase

    if (state_next == HOLD && state_reg != HOLD) begin
      in_pkt_next = 1'b0;
    end else if (beat) begin
      in_pkt_next = !tx_tlast;
    end else begin
      in_pkt_next = in_pkt_reg;
    end
  end

  always_comb begin
    tx_block = 1'b1;
    case (state_reg)
      RUN:     tx_block = 1'b0;
      DRAIN:   tx_block = !in_pkt_reg;
      default: tx_block = 1'b1;
    endcase
    busy = (state_reg != RUN);
  end

  assign port_softreset_n = softreset_n_reg;
  assign drain_timeout    = drain_timeout_reg;

endmodule

// File: rtl/pg_port_reset_ctrl.sv
// Port-gasket soft-reset controller: one independent sequencer per port,
// with each port's release offset by its index times STAGGER_CYCLES.
module pg_port_reset_ctrl
  import pg_port_reset_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT  = 1024,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] port_reset_req,
  input  logic [NUM_PORTS-1:0] tx_tvalid,
  input  logic [NUM_PORTS-1:0] tx_tready,
  input  logic [NUM_PORTS-1:0] tx_tlast,
  output logic [NUM_PORTS-1:0] tx_block,
  output logic [NUM_PORTS-1:0] port_softreset_n,
  output logic [NUM_PORTS-1:0] drain_timeout,
  output logic                 busy
);

  logic [NUM_PORTS-1:0] busy_vec;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      pg_port_reset_fsm #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
        .STAGGER_LOAD (gi * STAGGER_CYCLES)
      ) u_fsm (
        .clk             (clk),
        .rst             (rst),
        .port_reset_req  (port_reset_req[gi]),
        .tx_tvalid       (tx_tvalid[gi]),
        .tx_tready       (tx_tready[gi]),
        .tx_tlast        (tx_tlast[gi]),
        .tx_block        (tx_block[gi]),
        .port_softreset_n(port_softreset_n[gi]),
        .drain_timeout   (drain_timeout[gi]),
        .busy            (busy_vec[gi])
      );
    end
  endgenerate

  assign busy = |busy_vec;

endmodule

// File: tb/tb_pg_port_reset_ctrl.sv
// Randomized bench for pg_port_reset_ctrl against a timestamp-based model.
module tb_pg_port_reset_ctrl;

  localparam int NP   = 4;
  localparam int HOLD = 16;
  localparam int DTO  = 8;
  localparam int STG  = 4;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_LOW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NP-1:0] req, tvalid, tready, tlast;
  logic [NP-1:0] tx_block, srst_n, dto;
  logic          busy;

  always #5 clk = ~clk;

  pg_port_reset_ctrl #(
    .NUM_PORTS     (NP),
    .HOLD_CYCLES   (HOLD),
    .DRAIN_TIMEOUT (DTO),
    .STAGGER_CYCLES(STG)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .port_reset_req  (req),
    .tx_tvalid       (tvalid),
    .tx_tready       (tready),
    .tx_tlast        (tlast),
    .tx_block        (tx_block),
    .port_softreset_n(srst_n),
    .drain_timeout   (dto),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  // Model: per port a mode plus the edge numbers at which phases began.
  int m_mode[NP];
  int m_hold_start[NP];
  int m_stag_start[NP];
  int m_drain_start[NP];
  bit m_in_pkt[NP];
  bit m_dto[NP];

  bit req_lvl[NP];
  bit stall[NP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_cnt, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_mode[p]       = M_LOW;
      m_hold_start[p] = edge_cnt;
      m_stag_start[p] = -1;
      m_in_pkt[p]     = 1'b0;
      m_dto[p]        = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < NP; p++) begin
      bit beat, enter_low;
      beat      = tvalid[p] && tready[p];
      enter_low = 1'b0;
      case (m_mode[p])
        M_RUN: begin
          if (req[p]) begin
            m_mode[p]        = M_DRAIN;
            m_drain_start[p] = edge_cnt;
          end
        end
        M_DRAIN: begin
          if (!m_in_pkt[p] || (beat && tlast[p])) begin
            enter_low = 1'b1;
          end else if (edge_cnt - m_drain_start[p] >= DTO) begin
            enter_low = 1'b1;
            m_dto[p]  = 1'b1;
          end
        end
        default: begin
          if (m_stag_start[p] < 0) begin
            if (edge_cnt - m_hold_start[p] >= HOLD && !req[p]) m_stag_start[p] = edge_cnt;
          end else if (req[p]) begin
            enter_low = 1'b1;
          end else if (edge_cnt - m_stag_start[p] >= p * STG + 1) begin
            m_mode[p] = M_RUN;
            m_dto[p]  = 1'b0;
          end
        end
      endcase
      if (enter_low) begin
        m_mode[p]       = M_LOW;
        m_hold_start[p] = edge_cnt;
        m_stag_start[p] = -1;
        m_in_pkt[p]     = 1'b0;
      end else if (beat) begin
        m_in_pkt[p] = !tlast[p];
      end
    end
  endtask

  task automatic check_outputs();
    bit any_busy;
    any_busy = 1'b0;
    for (int p = 0; p < NP; p++) begin
      bit exp_block;
      exp_block = (m_mode[p] == M_RUN)   ? 1'b0 :
                  (m_mode[p] == M_DRAIN) ? !m_in_pkt[p] : 1'b1;
      check($sformatf("softreset_n[%0d]", p), 32'(srst_n[p]), 32'(m_mode[p] != M_LOW));
      check($sformatf("tx_block[%0d]", p), 32'(tx_block[p]), 32'(exp_block));
      check($sformatf("drain_timeout[%0d]", p), 32'(dto[p]), 32'(m_dto[p]));
      if (m_mode[p] != M_RUN) any_busy = 1'b1;
    end
    check("busy", 32'(busy), 32'(any_busy));
  endtask

  task automatic step();
    @(posedge clk);
    edge_cnt++;
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    req    = '0;
    tvalid = '0;
    tready = '0;
    tlast  = '0;
  endtask

  task automatic drive_random();
    for (int p = 0; p < NP; p++) begin
      if (req_lvl[p]) begin
        if ($urandom_range(0, 14) == 0) req_lvl[p] = 1'b0;
      end else begin
        if ($urandom_range(0, 39) == 0) req_lvl[p] = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) stall[p] = !stall[p];
      req[p]    = req_lvl[p] | ($urandom_range(0, 40) == 0);
      tvalid[p] = 1'($urandom_range(0, 1));
      tready[p] = stall[p] ? 1'b0 : ($urandom_range(0, 3) != 0);
      tlast[p]  = ($urandom_range(0, 5) == 0);
    end
  endtask

  // Called right after rst drops: idle inputs, measure release times.
  task automatic powerup_seq();
    int rel_base;
    int first_hi[NP];
    int busy_fall;
    drive_idle();
    rel_base  = edge_cnt;
    busy_fall = -1;
    for (int p = 0; p < NP; p++) first_hi[p] = -1;
    repeat (40) begin
      step();
      for (int p = 0; p < NP; p++)
        if (first_hi[p] < 0 && srst_n[p] === 1'b1) first_hi[p] = edge_cnt - rel_base;
      if (busy_fall < 0 && busy === 1'b0) busy_fall = edge_cnt - rel_base;
    end
    for (int p = 0; p < NP; p++)
      check($sformatf("release_cycles[%0d]", p), 32'(first_hi[p]), 32'(HOLD + p * STG + 1));
    check("busy_fall_cycles", 32'(busy_fall), 32'(HOLD + (NP - 1) * STG + 1));
  endtask

  initial begin
    drive_idle();
    for (int p = 0; p < NP; p++) begin
      req_lvl[p] = 1'b0;
      stall[p]   = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    repeat (5) step();
    rst = 1'b0;
    powerup_seq();

    repeat (3000) begin
      drive_random();
      step();
    end

    // Asynchronous reset landing between clock edges.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    for (int p = 0; p < NP; p++) req_lvl[p] = 1'b0;
    drive_idle();
    repeat (3) step();
    rst = 1'b0;
    powerup_seq();

    repeat (1500) begin
      drive_random();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pg_port_reset_ctrl.md
Name: pg_port_reset_ctrl

Overview:
- Per-port soft-reset sequencer for the port gasket. It generalises the single registered `rst_n && port_rst_n` term to NUM_PORTS independent channels.
- Each port reset is delayed until the AFU TX A stream reaches a packet boundary, or until a drain timeout expires. The reset is then held for a programmable time and released with a per-port stagger.
- Sits between the FIM port-reset sources and the PIM host-channel `reset_n` / TX mux of every port.

Parameters:
- NUM_PORTS, 4, number of independent ports (1..16).
- HOLD_CYCLES, 16, minimum cycles `port_softreset_n` stays low (>=1).
- DRAIN_TIMEOUT, 1024, maximum cycles spent in DRAIN before reset is forced (>=1).
- STAGGER_CYCLES, 4, release offset between consecutive port indices; port p releases p*STAGGER_CYCLES after its hold completes.

Ports:
- clk, in, 1, single clock for all logic.
- rst, in, 1, asynchronous active-high reset.
- port_reset_req, in, NUM_PORTS, per-port reset request, active-high, level.
- tx_tvalid, in, NUM_PORTS, AFU TX A tvalid monitor.
- tx_tready, in, NUM_PORTS, AFU TX A tready monitor.
- tx_tlast, in, NUM_PORTS, AFU TX A tlast monitor.
- tx_block, out, NUM_PORTS, 1 = mux must not accept a new packet start on port p.
- port_softreset_n, out, NUM_PORTS, registered active-low soft reset to PIM host channel p.
- drain_timeout, out, NUM_PORTS, sticky: port p was reset mid-packet; cleared on next RUN entry.
- busy, out, 1, OR over ports of (state != RUN).

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous, active-high.
- Values while rst is asserted:
  - `port_softreset_n = 0`, `tx_block = all 1`, `drain_timeout = 0`, `busy = 1`.
  - All ports are in HOLD with the hold counter loaded to HOLD_CYCLES-1 and `in_pkt = 0`.
- Packet tracking (per port): on a beat with tvalid&&tready, `in_pkt <= !tlast`. `in_pkt` clears when entering HOLD.
- Per-port FSM states: RUN, DRAIN, HOLD, STAGGER.
- RUN:
  - `port_softreset_n = 1`, `tx_block = 0`.
  - If `port_reset_req = 1`, go to DRAIN and load the drain counter to DRAIN_TIMEOUT-1.
- DRAIN:
  - `port_softreset_n = 1`, `tx_block = !in_pkt` (combinational from registered state).
  - Go to HOLD when `in_pkt = 0`, including a tlast beat this cycle. The transition is registered next cycle.
  - Otherwise, when the counter reaches 0, go to HOLD and set `drain_timeout`.
  - A request that drops during DRAIN does not abort: the reset completes.
- HOLD:
  - `port_softreset_n = 0`, `tx_block = 1`.
  - Decrement the hold counter. At 0 with `port_reset_req = 0`, go to STAGGER with the stagger counter loaded to p*STAGGER_CYCLES.
  - While the request stays high, remain in HOLD with the counter saturated at 0.
- STAGGER:
  - `port_softreset_n = 0`, `tx_block = 1`.
  - At counter 0, go to RUN. For port 0 the load value is 0, so STAGGER lasts 1 cycle.
  - If the request re-asserts in STAGGER, return to HOLD with the counter reloaded.
- Output registration: `port_softreset_n` is a flop driven from next-state, so it deasserts the same edge the FSM enters RUN.
- Latency:
  - Request rising with `in_pkt = 0`: softreset_n falls 2 edges later (RUN→DRAIN, DRAIN→HOLD).
  - Minimum low time: HOLD_CYCLES + p*STAGGER_CYCLES + 1.
- Counter widths: `$clog2(max value + 1)`. No wraparound, since counters only count down and saturate at 0.
- Simultaneous events on one edge:
  - tlast beat and drain counter reaching 0: treated as a clean drain, `drain_timeout` not set.
  - rst asserted mid-operation: immediately forces the reset values above. `drain_timeout` is lost.
- Port independence: ports are fully independent. Any mix of states is legal.

Decomposition:
- Package `pg_port_reset_pkg`:
  - `t_prst_state` enum {RUN, DRAIN, HOLD, STAGGER}.
  - Function `cnt_w(int max)` for counter widths.
- Sub-module `pg_port_reset_fsm`:
  - Single port; parameters HOLD_CYCLES, DRAIN_TIMEOUT, STAGGER_LOAD.
  - Instantiated NUM_PORTS times in a generate loop. The top computes STAGGER_LOAD = p*STAGGER_CYCLES and ORs `busy`.

Test Plan:
1. Power-up, defaults:
   - Stimulus: rst high 5 cycles then low, all requests 0.
   - Required: port0 softreset_n rises after 17 cycles, port1 after 21, port2 after 25, port3 after 29; busy falls with port3.
2. Idle port reset:
   - Stimulus: port1 in RUN, `port_reset_req[1]` pulsed 1 cycle.
   - Required: softreset_n[1] low 2 edges after the request, for exactly 16+4+1 = 21 cycles. Other ports are unaffected.
3. Mid-packet drain:
   - Stimulus: port2 mid 8-beat packet (3 beats sent) when the request asserts; remaining 5 beats sent back-to-back.
   - Required: tx_block[2] stays 0 until tlast; reset asserts the edge after tlast; drain_timeout[2] = 0.
4. Drain timeout:
   - Stimulus: DRAIN_TIMEOUT = 8, port0 mid-packet with tready held 0.
   - Required: after 8 DRAIN cycles softreset_n[0] falls, drain_timeout[0] = 1; it clears on the next RUN entry.
5. Held request and re-assert:
   - Stimulus: request held high 40 cycles.
   - Required: softreset_n stays 0 for the full 40 cycles plus the stagger. A re-assert during STAGGER restarts HOLD with a full 16 cycles.
6. Async reset mid-HOLD:
   - Stimulus: rst asserted between clock edges while port3 is in HOLD.
   - Required: all outputs take their reset values without waiting for a clock edge; the full power-up sequence from scenario 1 repeats.
